// File: rtl/clock_pkg.sv
// Shared types and timing helpers for the DE2 clock project input path.
// Build option: KEY_AUTOREPEAT_EN enables the key auto-repeat state.
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        PRESSED  = 3'd2,
        REPEAT   = 3'd3,
        DB_REL   = 3'd4
    } key_state_t;

    localparam int DEF_NUM_KEYS    = 4;
    localparam int DEF_CLK_HZ      = 50_000_000;
    localparam int DEF_DEBOUNCE_MS = 20;
    localparam int DEF_HOLD_MS     = 600;
    localparam int DEF_REPEAT_MS   = 150;

    // Divide first so 50 MHz * 600 ms stays inside a 32-bit int.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: two-flop synchroniser, debounce/hold FSM and counter.
// Build option: KEY_AUTOREPEAT_EN adds the REPEAT state and repeat_pulse.
module key_channel
    import clock_pkg::*;
#(
    parameter int DB_CYC   = 4,
`ifdef KEY_AUTOREPEAT_EN
    parameter int HOLD_CYC = 20,
    parameter int REP_CYC  = 5,
`endif
    parameter int CW       = 6
) (
    input  logic clk_50MHz,
    input  logic reset_n,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
`endif

    logic [1:0]    sync_q;
    logic          sync;
    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    // Synchroniser parks at "released" so reset never looks like a press.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign sync = ~sync_q[1];

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = DB_PRESS;
                    cnt_d   = CW'(1);
                end
            end
            DB_PRESS: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = DB_REL;
                    cnt_d   = CW'(1);
`ifdef KEY_AUTOREPEAT_EN
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            REPEAT: begin
                if (!sync) begin
                    state_d = DB_REL;
                    cnt_d   = CW'(1);
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            DB_REL: begin
                // A bounce back to pressed resumes the hold without a new press.
                if (sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_d = (state_q == DB_PRESS) && sync && (cnt_q == DB_LAST);
        rel_d   = (state_q == DB_REL) && !sync && (cnt_q == DB_LAST);
        level_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == DB_REL);
    end

`ifdef KEY_AUTOREPEAT_EN
    logic rep_q, rep_d;

    always_comb begin
        rep_d = sync && (((state_q == PRESSED) && (cnt_q == HOLD_LAST)) ||
                         ((state_q == REPEAT) && (cnt_q == REP_LAST)));
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low DE2 KEY lines into debounced levels and pulses.
// Build option: KEY_AUTOREPEAT_EN enables auto-repeat pulses while a key is held.
module key_conditioner
    import clock_pkg::*;
#(
    parameter int NUM_KEYS    = DEF_NUM_KEYS,
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int HOLD_MS     = DEF_HOLD_MS,
    parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
    input  logic                clk_50MHz,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    localparam int DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

`ifdef KEY_AUTOREPEAT_EN
    localparam int HOLD_CYC = ms_to_cycles(CLK_HZ, HOLD_MS);
    localparam int REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam int MAX_A    = (DB_CYC > HOLD_CYC) ? DB_CYC : HOLD_CYC;
    localparam int MAX_CYC  = (MAX_A > REP_CYC) ? MAX_A : REP_CYC;

    if (HOLD_CYC < 2) begin : g_bad_hold
        $error("key_conditioner: HOLD_MS gives fewer than 2 cycles");
    end
    if (REP_CYC < 2) begin : g_bad_rep
        $error("key_conditioner: REPEAT_MS gives fewer than 2 cycles");
    end
`else
    localparam int MAX_CYC  = DB_CYC;
`endif

    localparam int CW = $clog2(MAX_CYC) + 1;

    if (DB_CYC < 2) begin : g_bad_db
        $error("key_conditioner: DEBOUNCE_MS gives fewer than 2 cycles");
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_channel #(
            .DB_CYC       (DB_CYC),
`ifdef KEY_AUTOREPEAT_EN
            .HOLD_CYC     (HOLD_CYC),
            .REP_CYC      (REP_CYC),
`endif
            .CW           (CW)
        ) u_chan (
            .clk_50MHz    (clk_50MHz),
            .reset_n      (reset_n),
            .key_n        (key_n[gi]),
            .key_level    (key_level[gi]),
            .press_pulse  (press_pulse[gi]),
            .release_pulse(release_pulse[gi]),
            .repeat_pulse (repeat_pulse[gi])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner at DB_CYC=4, HOLD_CYC=20, REP_CYC=5.
// Repeat expectations follow KEY_AUTOREPEAT_EN when it is defined for the build.
module tb_key_conditioner;

    logic       clk_50MHz = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] key_n     = 4'hF;
    logic [3:0] key_level, press_pulse, release_pulse, repeat_pulse;

    always #5 clk_50MHz = ~clk_50MHz;

    key_conditioner #(
        .NUM_KEYS     (4),
        .CLK_HZ       (1000),
        .DEBOUNCE_MS  (4),
        .HOLD_MS      (20),
        .REPEAT_MS    (5)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset_n      (reset_n),
        .key_n        (key_n),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int press_cnt [4];
    int rel_cnt   [4];
    int rep_cnt   [4];
    int press_cyc [4];
    int rel_cyc   [4];
    int rep_first [4];
    int rep_last  [4];

    typedef struct {
        logic [3:0] key_n;
        int         adv;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
    } vec_t;

    vec_t vt [8];

    initial forever begin
        @(posedge clk_50MHz);
        cyc++;
    end

    // Pulse recorder; also checks that a key never shows two pulse kinds at once.
    initial forever begin
        @(negedge clk_50MHz);
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i]) begin
                if (press_cnt[i] == 0) press_cyc[i] = cyc;
                press_cnt[i]++;
            end
            if (release_pulse[i]) begin
                if (rel_cnt[i] == 0) rel_cyc[i] = cyc;
                rel_cnt[i]++;
            end
            if (repeat_pulse[i]) begin
                if (rep_cnt[i] == 0) rep_first[i] = cyc;
                rep_last[i] = cyc;
                rep_cnt[i]++;
            end
            if (press_pulse[i] || release_pulse[i] || repeat_pulse[i]) begin
                n_checks++;
                if (int'(press_pulse[i]) + int'(release_pulse[i]) + int'(repeat_pulse[i]) > 1) begin
                    n_fail++;
                    $display("FAIL exclusive key%0d: press=%b release=%b repeat=%b at cycle %0d",
                             i, press_pulse[i], release_pulse[i], repeat_pulse[i], cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; rep_cnt[i] = 0;
            press_cyc[i] = -1; rel_cyc[i] = -1; rep_first[i] = -1; rep_last[i] = -1;
        end
    endtask

    initial begin
        int e;
        int r;
        int drops;

        // key 1 clean press then release; inputs change #1 after an edge
        vt[0] = '{4'hF, 3,  4'h0, 4'h0, 4'h0};
        vt[1] = '{4'hD, 5,  4'h0, 4'h0, 4'h0};
        vt[2] = '{4'hD, 1,  4'h2, 4'h2, 4'h0};
        vt[3] = '{4'hD, 1,  4'h2, 4'h0, 4'h0};
        vt[4] = '{4'hD, 10, 4'h2, 4'h0, 4'h0};
        vt[5] = '{4'hF, 5,  4'h2, 4'h0, 4'h0};
        vt[6] = '{4'hF, 1,  4'h0, 4'h0, 4'h2};
        vt[7] = '{4'hF, 1,  4'h0, 4'h0, 4'h0};

        clear_counts();
        tick(3);
        check("reset_outputs", {key_level, press_pulse, release_pulse, repeat_pulse}, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            key_n = vt[i].key_n;
            tick(vt[i].adv);
            check($sformatf("vec%0d_level", i),  key_level,     vt[i].level);
            check($sformatf("vec%0d_press", i),  press_pulse,   vt[i].press);
            check($sformatf("vec%0d_rel", i),    release_pulse, vt[i].rel);
            check($sformatf("vec%0d_repeat", i), repeat_pulse,  4'h0);
            $display("vec%0d key_n=%b level=%b press=%b rel=%b", i, key_n, key_level, press_pulse, release_pulse);
        end

        // Bounce on key 0: 3 low / 2 high, five times
        clear_counts();
        for (int b = 0; b < 5; b++) begin
            key_n[0] = 1'b0; tick(3);
            key_n[0] = 1'b1; tick(2);
        end
        tick(8);
        check("bounce_press_cnt", press_cnt[0], 0);
        check("bounce_rel_cnt",   rel_cnt[0],   0);
        check("bounce_level",     key_level[0], 0);
        key_n[0] = 1'b0; tick(10);
        check("bounce_stable_press", press_cnt[0], 1);
        check("bounce_stable_level", key_level[0], 1);
        key_n[0] = 1'b1; tick(10);
        check("bounce_stable_rel", rel_cnt[0], 1);
        $display("bounce: press=%0d release=%0d", press_cnt[0], rel_cnt[0]);

        // Auto-repeat hold of key 2 for 60 cycles
        clear_counts();
        key_n[2] = 1'b0; e = cyc;
        tick(60);
        key_n[2] = 1'b1;
        tick(12);
        check("hold_press_cnt", press_cnt[2], 1);
        check("hold_press_lat", press_cyc[2] - e, 6);
        check("hold_rel_cnt",   rel_cnt[2], 1);
`ifdef KEY_AUTOREPEAT_EN
        check("hold_rep_cnt",    rep_cnt[2], 8);
        check("hold_rep_first",  rep_first[2] - press_cyc[2], 20);
        check("hold_rep_span",   rep_last[2] - rep_first[2], 35);
`else
        check("hold_rep_cnt",    rep_cnt[2], 0);
`endif
        $display("hold: press=%0d repeat=%0d release=%0d", press_cnt[2], rep_cnt[2], rel_cnt[2]);

        // Release glitch on held key 3
        clear_counts();
        key_n[3] = 1'b0; e = cyc;
        tick(10);
        drops = 0;
        key_n[3] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick(1);
            if (!key_level[3]) drops++;
        end
        key_n[3] = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick(1);
            if (!key_level[3]) drops++;
        end
        check("glitch_level_drops", drops, 0);
        check("glitch_rel_cnt",     rel_cnt[3], 0);
        check("glitch_press_cnt",   press_cnt[3], 1);
`ifdef KEY_AUTOREPEAT_EN
        check("glitch_hold_restart", rep_first[3] - press_cyc[3], 29);
`else
        check("glitch_rep_cnt", rep_cnt[3], 0);
`endif
        key_n[3] = 1'b1;
        tick(10);
        check("glitch_final_rel", rel_cnt[3], 1);
        $display("glitch: drops=%0d press=%0d release=%0d", drops, press_cnt[3], rel_cnt[3]);

        // Keys 0 and 3 pressed on the same edge
        clear_counts();
        key_n = 4'b0110; e = cyc;
        tick(10);
        check("simul_press0_cyc", press_cyc[0] - e, 6);
        check("simul_press3_cyc", press_cyc[3] - e, 6);
        check("simul_press_cnts", {press_cnt[0][7:0], press_cnt[3][7:0]}, 16'h0101);
        check("simul_level", key_level, 4'b1001);
        key_n = 4'hF; e = cyc;
        tick(10);
        check("simul_rel0_cyc", rel_cyc[0] - e, 6);
        check("simul_rel3_cyc", rel_cyc[3] - e, 6);
        $display("simul: press0=%0d press3=%0d", press_cnt[0], press_cnt[3]);

        // Reset while key 1 is held past the hold time
        clear_counts();
        key_n[1] = 1'b0;
        tick(35);
        check("rst_pre_level", key_level[1], 1);
        reset_n = 1'b0;
        tick(1);
        check("rst_outputs_zero", {key_level, press_pulse, release_pulse, repeat_pulse}, 0);
        tick(2);
        check("rst_rel_cnt", rel_cnt[1], 0);
        reset_n = 1'b1; r = cyc;
        clear_counts();
        tick(10);
        check("rst_repress_cnt", press_cnt[1], 1);
        check("rst_repress_lat", press_cyc[1] - r, 6);
        check("rst_repress_level", key_level[1], 1);
        key_n[1] = 1'b1;
        tick(10);
        check("rst_final_rel", rel_cnt[1], 1);
        $display("reset: re-press latency=%0d", press_cyc[1] - r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input-side conditioner for the DE2 push-buttons: synchronises, debounces and edge-detects the raw active-low `KEY` lines and produces clean single-cycle pulses. These pulses drive the clock, stopwatch and timer controls, such as `inc_minutes` and `start_stopwatch`. It sits between the board pins and the `clock` core, opposite the `seg7` display path. An optional auto-repeat generates periodic increment pulses while a key is held.

## Interface
- `NUM_KEYS`, 4: number of independent key channels.
- `CLK_HZ`, 50_000_000: frequency of `clk_50MHz`.
- `DEBOUNCE_MS`, 20: stable time required to accept a press or a release.
- `HOLD_MS`, 600: hold time before the first repeat pulse.
- `REPEAT_MS`, 150: period between subsequent repeat pulses.
- `clk_50MHz`, in, 1: the single clock; all logic is on its rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `key_n`, in, NUM_KEYS: raw asynchronous keys; 0 = pressed.
- `key_level`, out, NUM_KEYS: debounced pressed state; 1 = pressed.
- `press_pulse`, out, NUM_KEYS: one-cycle pulse when a press is accepted.
- `release_pulse`, out, NUM_KEYS: one-cycle pulse when a release is accepted.
- `repeat_pulse`, out, NUM_KEYS: one-cycle auto-repeat pulse while the key is held.

## Operation
- Derived constants:
  - DB_CYC = CLK_HZ/1000*DEBOUNCE_MS
  - HOLD_CYC = CLK_HZ/1000*HOLD_MS
  - REP_CYC = CLK_HZ/1000*REPEAT_MS
- Each constant must be ≥ 2; elaboration fails otherwise.
- Counter width is $clog2 of the largest constant, plus 1.
- Each key is an independent channel: a two-flop synchroniser, then one FSM and one counter.
- The synchroniser inverts its output, so `sync` = 1 means pressed.
- FSM states:
  - IDLE: if `sync`=1, go to DB_PRESS with cnt=1.
  - DB_PRESS:
    - If `sync`=0, return to IDLE.
    - Else if cnt==DB_CYC-1, go to PRESSED, assert `press_pulse` and clear cnt.
    - Else increment cnt.
  - PRESSED:
    - If `sync`=0, go to DB_REL with cnt=1.
    - Else if cnt==HOLD_CYC-1, go to REPEAT, assert `repeat_pulse` and clear cnt.
    - Else increment cnt.
  - REPEAT:
    - If `sync`=0, go to DB_REL with cnt=1.
    - Else if cnt==REP_CYC-1, assert `repeat_pulse` and clear cnt.
    - Else increment cnt.
  - DB_REL:
    - If `sync`=1, go to PRESSED with cnt=0; the hold timer restarts and no new `press_pulse` is issued.
    - Else if cnt==DB_CYC-1, go to IDLE and assert `release_pulse`.
    - Else increment cnt.
- `key_level` = 1 in PRESSED, REPEAT and DB_REL.
- `key_level` rises in the same cycle as `press_pulse` and falls in the same cycle as `release_pulse`.
- Pulses on any key are mutually exclusive per key; simultaneous activity on different keys is fully independent.
- A glitch shorter than DB_CYC cycles produces no output.
- Reset:
  - All outputs, FSMs and counters go to 0/IDLE.
  - Synchroniser flops are set to 1 (released).
  - Reset asserted mid-press drops all outputs to 0 at the next edge, with no `release_pulse`.
  - A key still held after reset release is debounced afresh and yields a `press_pulse`.

## Timing
- All outputs are registered.
- Key held stable from a `key_n` fall sampled at edge k: `press_pulse` is high during the cycle after edge k+1+DB_CYC, i.e. latency DB_CYC+2.
- First `repeat_pulse` comes HOLD_CYC cycles after `press_pulse`; subsequent repeat pulses every REP_CYC cycles.
- Key held stable from a `key_n` rise sampled at edge r: `release_pulse` has latency DB_CYC+2, and the same cycle has `key_level`=0.
- Minimum spacing between a press and its release pulse is DB_CYC cycles.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: REPEAT state and `repeat_pulse` are generated as above.
- `KEY_AUTOREPEAT_EN` undefined:
  - PRESSED holds without counting; REPEAT state is not built.
  - `repeat_pulse` is tied to 0, and the HOLD_MS/REPEAT_MS parameters are ignored.

## Structure
- Shared package `clock_pkg`:
  - `key_state_t` enum (IDLE, DB_PRESS, PRESSED, REPEAT, DB_REL).
  - `ms_to_cycles(clk_hz, ms)` function.
  - Default timing constants.
- Sub-module `key_channel`: synchroniser, FSM and counter for one key.
- `key_conditioner` is a generate loop over NUM_KEYS instances of `key_channel`.

## Test plan
All scenarios use CLK_HZ=1000, DEBOUNCE_MS=4, HOLD_MS=20, REPEAT_MS=5, which gives DB_CYC=4, HOLD_CYC=20, REP_CYC=5.
- Clean press of key 1: `key_n[1]` low at edge 10 → `press_pulse[1]` one cycle at cycle 16 and `key_level[1]` high from cycle 16. Then release at edge 40 → `release_pulse[1]` at cycle 46.
- Bounce: `key_n[0]` low for 3 cycles, high for 2, repeated 5 times → no pulses and `key_level`=0. A subsequent stable press → exactly one `press_pulse`.
- Auto-repeat (macro defined): hold key 2 for 60 cycles → `press_pulse` at cycle t, then `repeat_pulse` at t+20, t+25, t+30, and so on. With the macro undefined → zero `repeat_pulse`.
- Release glitch: held key 3 goes high for 2 cycles → no `release_pulse`, `key_level` stays 1, hold timer restarts.
- Simultaneous: keys 0 and 3 pressed on the same edge → both `press_pulse` bits in the same cycle, each exactly once.
- Reset mid-hold: `reset_n`=0 while key 1 is in REPEAT → all outputs 0 the next cycle. Key still held after reset release → `press_pulse` at DB_CYC+2 cycles after release.
